kogge_stone_adder_pipe: RTL and testbench



---
 rtl/kogge_stone_adder_pipe_pkg.sv | 25 ++
 rtl/kogge_stone_adder_pipe_prefix_level.sv | 20 ++
 rtl/kogge_stone_adder_pipe.sv | 129 ++++++++++++
 tb/tb_kogge_stone_adder_pipe.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/kogge_stone_adder_pipe_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder: sizing functions and the (G,P) pair type.
package kogge_stone_adder_pipe_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Number of registered prefix groups; the last group may hold fewer levels.
  function automatic int ngrp(input int width, input int lps);
    return (clog2(width) + lps - 1) / lps;
  endfunction

  function automatic int lat(input int width, input int lps);
    return ngrp(width, lps) + 2;
  endfunction

endpackage

// File: rtl/kogge_stone_adder_pipe_prefix_level.sv
// One combinational Kogge-Stone level: bit i absorbs the group ending DIST bits below it.
module kogge_stone_adder_pipe_prefix_level
  import kogge_stone_adder_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  gp_t [WIDTH-1:0] gp_in,
  output gp_t [WIDTH-1:0] gp_out
);

  always_comb begin
    gp_out = gp_in;
    for (int i = DIST; i < WIDTH; i++) begin
      gp_out[i].g = gp_in[i].g | (gp_in[i].p & gp_in[i-DIST].g);
      gp_out[i].p = gp_in[i].p & gp_in[i-DIST].p;
    end
  end

endmodule

// File: rtl/kogge_stone_adder_pipe.sv
// Pipelined Kogge-Stone adder: G/P stage, ceil(log2(WIDTH)/LPS) prefix stages, registered sum.
// Latency NGRP+2; global stall, in_ready = ~out_valid | out_ready, so a held result freezes every stage.
module kogge_stone_adder_pipe
  import kogge_stone_adder_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LPS   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int LEVELS = clog2(WIDTH);
  localparam int NGRP   = ngrp(WIDTH, LPS);

  gp_t  [WIDTH-1:0] gp_q    [NGRP+1];
  gp_t  [WIDTH-1:0] gp_d    [NGRP+1];
  logic [WIDTH-1:0] p_q     [NGRP+1];
  logic [WIDTH-1:0] p_d     [NGRP+1];
  logic [NGRP:0]    cin_q, cin_d, vld_q, vld_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_valid_q, out_valid_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;
  logic             adv;
  logic [WIDTH-1:0] g_fin;
  gp_t  [WIDTH-1:0] lvl_out [LEVELS];
  gp_t  [WIDTH-1:0] grp_out [1:NGRP];

  // Each group starts from the stage register and chains its levels combinationally.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    gp_t [WIDTH-1:0] lvl_in;
    if (l % LPS == 0) begin : g_first
      assign lvl_in = gp_q[l / LPS];
    end else begin : g_chain
      assign lvl_in = lvl_out[l-1];
    end
    kogge_stone_adder_pipe_prefix_level #(
      .WIDTH(WIDTH),
      .DIST (1 << l)
    ) u_level (
      .gp_in (lvl_in),
      .gp_out(lvl_out[l])
    );
  end

  for (genvar k = 1; k <= NGRP; k++) begin : g_grp
    localparam int LAST = ((k * LPS < LEVELS) ? k * LPS : LEVELS) - 1;
    assign grp_out[k] = lvl_out[LAST];
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) g_fin[i] = gp_q[NGRP][i].g;
  end

  always_comb begin
    adv         = ~out_valid_q | out_ready;
    gp_d        = gp_q;
    p_d         = p_q;
    cin_d       = cin_q;
    vld_d       = vld_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    if (adv) begin
      vld_d[0] = in_valid;
      cin_d[0] = in_cin;
      p_d[0]   = in_a ^ in_b;
      for (int i = 0; i < WIDTH; i++) begin
        gp_d[0][i].p = in_a[i] ^ in_b[i];
        gp_d[0][i].g = in_a[i] & in_b[i];
      end
      // Folding cin into bit 0 makes G[i] the true carry out of bit i.
      gp_d[0][0].g = (in_a[0] & in_b[0]) | ((in_a[0] ^ in_b[0]) & in_cin);
      for (int k = 1; k <= NGRP; k++) begin
        gp_d[k]  = grp_out[k];
        p_d[k]   = p_q[k-1];
        cin_d[k] = cin_q[k-1];
        vld_d[k] = vld_q[k-1];
      end
      out_valid_d = vld_q[NGRP];
      out_sum_d   = p_q[NGRP] ^ {g_fin[WIDTH-2:0], cin_q[NGRP]};
      out_cout_d  = g_fin[WIDTH-1];
      out_ovf_d   = g_fin[WIDTH-1] ^ g_fin[WIDTH-2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= NGRP; k++) begin
        gp_q[k] <= '0;
        p_q[k]  <= '0;
      end
      cin_q       <= '0;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      gp_q        <= gp_d;
      p_q         <= p_d;
      cin_q       <= cin_d;
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_kogge_stone_adder_pipe.sv
// Bench for kogge_stone_adder_pipe: three configurations share one stimulus stream, each with its own scoreboard.
module tb_kogge_stone_adder_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_cin = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;

  logic [2:0]  rdy_v, vld_v, cout_v, ovf_v;
  logic [7:0]  sum0, sum2;
  logic [31:0] sum1;

  int n_chk = 0;
  int n_err = 0;
  int acc1 = 0;
  int acc2 = 0;
  int pop0 = 0;
  logic [33:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  // dut0: WIDTH=8 LPS=1 (LAT 5); dut1: WIDTH=32 LPS=2 (LAT 5); dut2: WIDTH=8 LPS=3 (LAT 3)
  kogge_stone_adder_pipe #(.WIDTH(8), .LPS(1)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_v[0]),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_cin(in_cin),
    .out_valid(vld_v[0]), .out_ready(out_ready), .out_sum(sum0),
    .out_cout(cout_v[0]), .out_ovf(ovf_v[0]));

  kogge_stone_adder_pipe #(.WIDTH(32), .LPS(2)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_v[1]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(vld_v[1]), .out_ready(out_ready), .out_sum(sum1),
    .out_cout(cout_v[1]), .out_ovf(ovf_v[1]));

  kogge_stone_adder_pipe #(.WIDTH(8), .LPS(3)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_v[2]),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_cin(in_cin),
    .out_valid(vld_v[2]), .out_ready(out_ready), .out_sum(sum2),
    .out_cout(cout_v[2]), .out_ovf(ovf_v[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer addition; result packed as {ovf, cout, sum}.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin);
    logic [32:0] full;
    logic [31:0] mask, s;
    logic        co, ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    full = {1'b0, a & mask} + {1'b0, b & mask} + {32'd0, cin};
    s    = full[31:0] & mask;
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  // Scoreboard: handshakes are judged on the values present just before each rising edge.
  always @(negedge clk) begin
    if (reset) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      for (int k = 0; k < 3; k++) chk("in_ready_rule", 64'(rdy_v[k]), 64'(!vld_v[k] || out_ready));
      if (in_valid && rdy_v[0]) q0.push_back(model(8, in_a, in_b, in_cin));
      if (in_valid && rdy_v[1]) begin q1.push_back(model(32, in_a, in_b, in_cin)); acc1++; end
      if (in_valid && rdy_v[2]) begin q2.push_back(model(8, in_a, in_b, in_cin)); acc2++; end
      if (vld_v[0] && out_ready) begin
        pop0++;
        chk("spurious0", 64'(q0.size() != 0), 64'd1);
        if (q0.size() != 0) chk("res0", {30'b0, ovf_v[0], cout_v[0], 24'b0, sum0}, {30'b0, q0.pop_front()});
      end
      if (vld_v[1] && out_ready) begin
        chk("spurious1", 64'(q1.size() != 0), 64'd1);
        if (q1.size() != 0) chk("res1", {30'b0, ovf_v[1], cout_v[1], sum1}, {30'b0, q1.pop_front()});
      end
      if (vld_v[2] && out_ready) begin
        chk("spurious2", 64'(q2.size() != 0), 64'd1);
        if (q2.size() != 0) chk("res2", {30'b0, ovf_v[2], cout_v[2], 24'b0, sum2}, {30'b0, q2.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single op on dut0: accept edge counts as 1, result must be visible after edge 5.
  task automatic op0(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic ec, input logic eo);
    int n;
    in_valid  = 1'b1;
    in_a      = {24'h0, a};
    in_b      = {24'h0, b};
    in_cin    = c;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n = 1;
    while (!vld_v[0] && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd5);
    chk({tag, "_sum"}, 64'(sum0), 64'(es));
    chk({tag, "_cout"}, 64'(cout_v[0]), 64'(ec));
    chk({tag, "_ovf"}, 64'(ovf_v[0]), 64'(eo));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sa[10];
    logic [7:0] sb[10];
    logic       sc[10];
    int         idx, p_start, a1_start, a2_start, cyc;
    logic       stall;

    repeat (3) step();
    chk("rst_vld", 64'(vld_v), 64'd0);
    chk("rst_sum0", 64'(sum0), 64'd0);
    chk("rst_sum1", 64'(sum1), 64'd0);
    chk("rst_rdy", 64'(rdy_v), 64'h7);
    reset = 1'b0;
    step();

    op0("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op0("7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op0("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    op0("aa_55", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
    op0("zero_c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    step();

    // Ten back-to-back ops with out_ready low for cycles 6..8.
    for (int i = 0; i < 10; i++) begin
      sa[i] = 8'($urandom());
      sb[i] = 8'($urandom());
      sc[i] = 1'($urandom());
    end
    p_start = pop0;
    idx = 0;
    for (int c = 0; c < 22; c++) begin
      stall     = (c >= 6 && c <= 8);
      out_ready = !stall;
      in_valid  = (idx < 10);
      if (idx < 10) begin
        in_a   = {24'h0, sa[idx]};
        in_b   = {24'h0, sb[idx]};
        in_cin = sc[idx];
      end
      #1;
      if (c <= 12) chk("stream_rdy", 64'(rdy_v[0]), 64'(!stall));
      if (stall)
        chk("stream_hold", {30'b0, ovf_v[0], cout_v[0], 24'b0, sum0},
            {30'b0, model(8, {24'h0, sa[1]}, {24'h0, sb[1]}, sc[1])});
      if (idx < 10 && !stall) idx++;
      @(posedge clk);
      #1;
    end
    chk("stream_count", 64'(pop0 - p_start), 64'd10);
    chk("stream_drain", 64'(q0.size()), 64'd0);

    // Reset with three ops in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = $urandom();
      in_b     = $urandom();
      in_cin   = 1'($urandom());
      step();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    chk("midrst_vld", 64'(vld_v), 64'd0);
    chk("midrst_sum0", 64'(sum0), 64'd0);
    chk("midrst_rdy", 64'(rdy_v), 64'h7);
    reset = 1'b0;
    repeat (8) step();
    op0("post_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // Random traffic until both random-test configurations have accepted 1000 ops.
    a1_start = acc1;
    a2_start = acc2;
    cyc = 0;
    while (((acc1 - a1_start) < 1000 || (acc2 - a2_start) < 1000) && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = $urandom();
      in_b      = $urandom();
      in_cin    = 1'($urandom());
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) step();
    chk("rand_acc1", 64'((acc1 - a1_start) >= 1000), 64'd1);
    chk("rand_acc2", 64'((acc2 - a2_start) >= 1000), 64'd1);
    chk("drain0", 64'(q0.size()), 64'd0);
    chk("drain1", 64'(q1.size()), 64'd0);
    chk("drain2", 64'(q2.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
